// File: rtl/func_min_pkg.sv
// Shared constants and types for the exhaustive sweep-and-capture stage
// around the 4-input minimised function block.
package func_min_pkg;

    localparam int IDX_W   = 4;
    localparam int NUM_VEC = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Position of each function input within the vector index; a is the MSB.
    localparam int A_BIT = 3;
    localparam int B_BIT = 2;
    localparam int C_BIT = 1;
    localparam int D_BIT = 0;

endpackage

// File: rtl/func_hold_timer.sv
// Down-counter that emits a one-cycle tick every HOLD_CYCLES enabled cycles;
// i_load rearms it so the first tick lands HOLD_CYCLES cycles after the load.
module func_hold_timer #(
    parameter int HOLD_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_load,
    input  logic i_en,
    output logic o_tick
);

    localparam int              CNT_W  = 8;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(HOLD_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;

    assign o_tick = i_en && (r_cnt == '0);

    // NOTE: registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of always_ff evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load || o_tick) begin
            r_cnt <= RELOAD;
        end else if (i_en) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

endmodule

// File: rtl/func_sweep_capture.sv
// Drives all 16 input combinations onto the minimised function, captures z
// for each into a truth table and compares it against the EXPECTED table.
module func_sweep_capture
    import func_min_pkg::*;
#(
    parameter int          HOLD_CYCLES = 4,
    parameter logic [15:0] EXPECTED    = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    input  logic        z,
    output logic        busy,
    output logic        done,
    output logic [15:0] truth_table,
    output logic [15:0] mismatch,
    output logic [4:0]  err_count,
    output logic        pass
);

    if (HOLD_CYCLES < 1 || HOLD_CYCLES > 255) begin : g_bad_hold
        $error("func_sweep_capture: HOLD_CYCLES must be within 1..255");
    end

    state_t             r_state;
    logic [IDX_W-1:0]   r_idx;
    logic               r_busy;
    logic               r_done;
    logic [NUM_VEC-1:0] r_truth;
    logic [NUM_VEC-1:0] r_mismatch;
    logic [4:0]         r_err;

    logic               w_start_go;
    logic               w_tick;
    logic               w_last;
    logic [NUM_VEC-1:0] w_truth_next;
    logic [NUM_VEC-1:0] w_mismatch_next;
    logic [4:0]         w_err_next;

    // start is only honoured outside a sweep; it also rearms the hold timer.
    assign w_start_go = start && (r_state != DRIVE);
    assign w_last     = (r_idx == IDX_W'(NUM_VEC - 1));

    func_hold_timer #(
        .HOLD_CYCLES(HOLD_CYCLES)
    ) u_hold_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_start_go),
        .i_en   (r_state == DRIVE),
        .o_tick (w_tick)
    );

    // NOTE: every signal is given a default before any conditional update
    // so the block stays purely combinational and no latch is inferred.
    always_comb begin
        w_truth_next        = r_truth;
        w_truth_next[r_idx] = z;
        w_mismatch_next     = w_truth_next ^ EXPECTED;
        w_err_next          = '0;
        for (int i = 0; i < NUM_VEC; i++) begin
            w_err_next = w_err_next + 5'(w_mismatch_next[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_idx      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_truth    <= '0;
            r_mismatch <= '0;
            r_err      <= '0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_state    <= DRIVE;
                        r_idx      <= '0;
                        r_busy     <= 1'b1;
                        r_done     <= 1'b0;
                        r_truth    <= '0;
                        r_mismatch <= '0;
                        r_err      <= '0;
                    end
                end
                DRIVE: begin
                    if (w_tick) begin
                        r_truth <= w_truth_next;
                        // Compare on the final capture so results are valid in the first DONE cycle.
                        if (w_last) begin
                            r_state    <= DONE;
                            r_busy     <= 1'b0;
                            r_done     <= 1'b1;
                            r_mismatch <= w_mismatch_next;
                            r_err      <= w_err_next;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign a           = r_idx[A_BIT];
    assign b           = r_idx[B_BIT];
    assign c           = r_idx[C_BIT];
    assign d           = r_idx[D_BIT];
    assign busy        = r_busy;
    assign done        = r_done;
    assign truth_table = r_truth;
    assign mismatch    = r_mismatch;
    assign err_count   = r_err;
    assign pass        = r_done && (r_err == '0);

endmodule

// File: tb/tb_func_sweep_capture.sv
// Directed bench: four sweep-capture instances (correct, single-fault,
// all-fault, HOLD_CYCLES=1) checked against hand-computed truth tables.
module tb_func_sweep_capture;

    localparam int NI = 4;

    typedef struct {
        logic [15:0] tt;
        logic [15:0] mm;
        logic [4:0]  err;
        logic        pass;
    } res_t;

    logic clk = 1'b0;
    logic rst_n;
    logic start_m;
    logic start_h1;

    logic        a_o    [NI];
    logic        b_o    [NI];
    logic        c_o    [NI];
    logic        d_o    [NI];
    logic        z_i    [NI];
    logic        busy_o [NI];
    logic        done_o [NI];
    logic        pass_o [NI];
    logic [15:0] tt_o   [NI];
    logic [15:0] mm_o   [NI];
    logic [4:0]  err_o  [NI];

    res_t res_tab [NI];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Instance 0: correct table; 1: one-bit wrong table; 2: z stuck at 0;
    // 3: HOLD_CYCLES=1 with z = a ^ d.
    for (genvar g = 0; g < NI; g++) begin : g_dut
        func_sweep_capture #(
            .HOLD_CYCLES((g == 3) ? 1 : 4),
            .EXPECTED   ((g == 0) ? 16'hF444 : (g == 1) ? 16'hF445 :
                         (g == 2) ? 16'hFFFF : 16'h55AA)
        ) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .start      ((g == 3) ? start_h1 : start_m),
            .a          (a_o[g]),
            .b          (b_o[g]),
            .c          (c_o[g]),
            .d          (d_o[g]),
            .z          (z_i[g]),
            .busy       (busy_o[g]),
            .done       (done_o[g]),
            .truth_table(tt_o[g]),
            .mismatch   (mm_o[g]),
            .err_count  (err_o[g]),
            .pass       (pass_o[g])
        );

        if (g == 2) begin : g_z0
            assign z_i[g] = 1'b0;
        end else if (g == 3) begin : g_zx
            assign z_i[g] = a_o[g] ^ d_o[g];
        end else begin : g_zf
            assign z_i[g] = (a_o[g] & b_o[g]) | (c_o[g] & ~d_o[g]);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] vec_of(input int i);
        return {a_o[i], b_o[i], c_o[i], d_o[i]};
    endfunction

    task automatic check_results(input string tag, input int first, input int last);
        for (int i = first; i <= last; i++) begin
            check($sformatf("%s[%0d].done", tag, i), 32'(done_o[i]), 32'd1);
            check($sformatf("%s[%0d].busy", tag, i), 32'(busy_o[i]), 32'd0);
            check($sformatf("%s[%0d].tt", tag, i), 32'(tt_o[i]), 32'(res_tab[i].tt));
            check($sformatf("%s[%0d].mm", tag, i), 32'(mm_o[i]), 32'(res_tab[i].mm));
            check($sformatf("%s[%0d].err", tag, i), 32'(err_o[i]), 32'(res_tab[i].err));
            check($sformatf("%s[%0d].pass", tag, i), 32'(pass_o[i]), 32'(res_tab[i].pass));
            check($sformatf("%s[%0d].vec", tag, i), 32'(vec_of(i)), 32'hF);
        end
    endtask

    task automatic check_reset_state(input string tag);
        for (int i = 0; i < NI; i++) begin
            check($sformatf("%s[%0d].vec", tag, i), 32'(vec_of(i)), 32'h0);
            check($sformatf("%s[%0d].busy", tag, i), 32'(busy_o[i]), 32'd0);
            check($sformatf("%s[%0d].done", tag, i), 32'(done_o[i]), 32'd0);
            check($sformatf("%s[%0d].tt", tag, i), 32'(tt_o[i]), 32'h0);
            check($sformatf("%s[%0d].mm", tag, i), 32'(mm_o[i]), 32'h0);
            check($sformatf("%s[%0d].err", tag, i), 32'(err_o[i]), 32'd0);
            check($sformatf("%s[%0d].pass", tag, i), 32'(pass_o[i]), 32'd0);
        end
    endtask

    initial begin
        int busy_cnt0;
        int busy_cnt3;

        // (a&b)|(c&~d): indices 12..15 plus 2,6,10,14 -> 16'hF444.
        // a^d: indices 1,3,5,7,8,10,12,14 -> 16'h55AA.
        res_tab[0] = '{tt: 16'hF444, mm: 16'h0000, err: 5'd0,  pass: 1'b1};
        res_tab[1] = '{tt: 16'hF444, mm: 16'h0001, err: 5'd1,  pass: 1'b0};
        res_tab[2] = '{tt: 16'h0000, mm: 16'hFFFF, err: 5'd16, pass: 1'b0};
        res_tab[3] = '{tt: 16'h55AA, mm: 16'h0000, err: 5'd0,  pass: 1'b1};

        rst_n    = 1'b0;
        start_m  = 1'b0;
        start_h1 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_state("por");
        rst_n = 1'b1;

        // Sweep 1: start pulse, plus ignored start pulses at DRIVE cycles 5 and 20.
        @(negedge clk);
        start_m  = 1'b1;
        start_h1 = 1'b1;
        busy_cnt0 = 0;
        busy_cnt3 = 0;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (k == 0) begin
                start_h1 = 1'b0;
                start_m  = 1'b0;
            end
            if (busy_o[0]) busy_cnt0++;
            if (busy_o[3]) busy_cnt3++;
            check($sformatf("s1.k%0d.vec0", k), 32'(vec_of(0)), 32'(k / 4));
            check($sformatf("s1.k%0d.busy0", k), 32'(busy_o[0]), 32'd1);
            check($sformatf("s1.k%0d.done0", k), 32'(done_o[0]), 32'd0);
            if (k < 16) begin
                check($sformatf("s1.k%0d.vec3", k), 32'(vec_of(3)), 32'(k));
                check($sformatf("s1.k%0d.busy3", k), 32'(busy_o[3]), 32'd1);
            end else begin
                check($sformatf("s1.k%0d.done3", k), 32'(done_o[3]), 32'd1);
            end
            if (k == 5 || k == 20) start_m = 1'b1;
            if (k == 6 || k == 21) start_m = 1'b0;
        end
        @(negedge clk);
        check("s1.busy_cycles0", 32'(busy_cnt0), 32'd64);
        check("s1.busy_cycles3", 32'(busy_cnt3), 32'd16);
        check_results("s1", 0, NI - 1);

        // Restart from DONE with start held high: results clear on the restart edge.
        start_m = 1'b1;
        @(negedge clk);
        check("rs.done0", 32'(done_o[0]), 32'd0);
        check("rs.busy0", 32'(busy_o[0]), 32'd1);
        check("rs.vec0", 32'(vec_of(0)), 32'h0);
        check("rs.tt2", 32'(tt_o[2]), 32'h0);
        check("rs.mm2", 32'(mm_o[2]), 32'h0);
        check("rs.err2", 32'(err_o[2]), 32'd0);
        check("rs.pass0", 32'(pass_o[0]), 32'd0);
        busy_cnt0 = 1;
        for (int k = 1; k < 64; k++) begin
            @(negedge clk);
            if (busy_o[0]) busy_cnt0++;
        end
        @(negedge clk);
        check("s2.busy_cycles0", 32'(busy_cnt0), 32'd64);
        check_results("s2", 0, 2);

        // Start still high: exactly one DONE cycle before the next sweep begins.
        @(negedge clk);
        start_m = 1'b0;
        check("b2b.busy0", 32'(busy_o[0]), 32'd1);
        check("b2b.done0", 32'(done_o[0]), 32'd0);
        check("b2b.tt0", 32'(tt_o[0]), 32'h0);

        // Reset in the middle of the sweep at idx 7.
        repeat (28) @(negedge clk);
        check("mid.vec0", 32'(vec_of(0)), 32'h7);
        rst_n = 1'b0;
        #1;
        check_reset_state("mid_rst");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post.busy0", 32'(busy_o[0]), 32'd0);
        check("post.done0", 32'(done_o[0]), 32'd0);
        check("post.vec0", 32'(vec_of(0)), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
